core_mem_arbiter: RTL
=====================

// Module: core_mem_arbiter
// PURPOSE
//  Downstream of the mar810 core: merges its instruction port (qword reads) and data port
//  (word read/write with byte enables) onto one 32-bit Avalon-MM master with waitrequest.
//  Latches each start pulse, arbitrates, splits a qword fetch into two word beats,
//  and returns a one-cycle ready pulse per completed request.
// PARAMETERS
//  DATA_FIRST  1  1: a pending data request wins over a pending insn request in IDLE; 0: insn wins
//  HI_FIRST    0  1: fetch the high word (+4) before the low word (+0); 0: low word first
// PORTS
//  clk            in   1    core clock
//  rst_n          in   1    synchronous active-low reset
//  insn_start     in   1    pulse: latch insn_addr, request qword fetch
//  insn_addr      in   29   qword address (qptr); byte address = {insn_addr,3'b000}
//  insn_ready     out  1    pulse: insn_data_rd valid
//  insn_data_rd   out  64   {word@+4, word@+0}
//  data_start     in   1    pulse: latch data_addr/data_write/data_data_wr/data_data_be
//  data_addr      in   30   word address (ptr); byte address = {data_addr,2'b00}
//  data_write     in   1    1 write, 0 read
//  data_data_wr   in   32   write data
//  data_data_be   in   4    byte enables (writes and reads)
//  data_ready     out  1    pulse: data access done; data_data_rd valid for reads
//  data_data_rd   out  32   read data
//  avl_address    out  32   byte address
//  avl_read       out  1    read strobe
//  avl_write      out  1    write strobe
//  avl_writedata  out  32   write data
//  avl_byteenable out  4    byte enables
//  avl_readdata   in   32   valid when avl_read && !avl_waitrequest
//  avl_waitrequest in  1    slave stall; master holds all avl_* outputs stable while high
// BEHAVIOUR
//  Reset (rst_n low at posedge): state IDLE; both pending flags clear; insn_ready, data_ready,
//   avl_read, avl_write = 0; avl_address, avl_writedata, avl_byteenable,
//   insn_data_rd, data_data_rd = 0. Reset mid-transfer drops strobes on that edge and discards
//   pending requests; no ready is issued for them.
//  Capture: a start pulse sets the port's pending flag and registers its operands. A start
//   while that port is pending or in service is a protocol violation; it is ignored.
//   A start in the same cycle as that port's ready pulse is accepted.
//  FSM states: IDLE, INSN_B0, INSN_B1, DATA.
//   IDLE: both pending -> DATA if DATA_FIRST else INSN_B0; only one pending -> its state.
//    Capture and grant are never in the same cycle: a start seen in IDLE is granted next cycle.
//   INSN_B0: avl_read=1, be=4'hF, address = first word (+0, or +4 if HI_FIRST).
//    !waitrequest: store readdata into its half -> INSN_B1.
//   INSN_B1: same for the other word. !waitrequest: store it, clear insn pending,
//    insn_ready=1 next cycle -> IDLE.
//   DATA: avl_read = !write, avl_write = write, be = latched be, writedata = latched data.
//    !waitrequest: on reads latch readdata into data_data_rd; clear data pending;
//    data_ready=1 next cycle -> IDLE.
//  A qword fetch is never interleaved with a data beat.
//  Ready pulses last exactly one cycle. insn_data_rd / data_data_rd hold until the next
//   completion on their port. data_data_rd is unchanged by writes.
//  Minimum latency with waitrequest=0: data start -> ready = 2 cycles;
//   insn start -> ready = 3 cycles.
//  The arbiter returns to IDLE for one cycle between grants, giving one bubble cycle per request.
//  Unused avl_* outputs hold their last value when not strobed.
//  Address arithmetic is concatenation only; no carry from +4 into insn_addr.
// TESTING
//  1 insn_start addr=29'h0000010, waitreq=0, mem[0x80]=A, [0x84]=B -> reads 0x80 then 0x84,
//    insn_ready at +3, insn_data_rd=={B,A}
//  2 data write addr=30'h40, be=4'b0110, wr=32'hDEADBEEF -> one cycle avl_write, address 0x100,
//    be 0110; data_ready at +2
//  3 insn_start and data_start same cycle, DATA_FIRST=1 -> data beat, IDLE, then two insn beats;
//    each port gets exactly one ready
//  4 waitrequest high 3 cycles on INSN_B1 -> address/read stable throughout; ready 3 cycles late;
//    low word preserved
//  5 rst_n low during INSN_B0 -> avl_read=0 next edge, no insn_ready; a fresh request after
//    reset completes normally
//  6 data_start on the data_ready cycle -> accepted; second access issued after one IDLE cycle

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Merges the core's qword instruction port and word data port onto one 32-bit
// Avalon-MM master with waitrequest; one ready pulse per completed request.
module core_mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1,
  parameter bit HI_FIRST   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        insn_start,
  input  logic [28:0] insn_addr,
  output logic        insn_ready,
  output logic [63:0] insn_data_rd,
  input  logic        data_start,
  input  logic [29:0] data_addr,
  input  logic        data_write,
  input  logic [31:0] data_data_wr,
  input  logic [3:0]  data_data_be,
  output logic        data_ready,
  output logic [31:0] data_data_rd,
  output logic [31:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [31:0] avl_writedata,
  output logic [3:0]  avl_byteenable,
  input  logic [31:0] avl_readdata,
  input  logic        avl_waitrequest
);

  typedef enum logic [1:0] {S_IDLE, S_INSN_B0, S_INSN_B1, S_DATA} state_t;

  localparam logic [2:0] FIRST_OFF  = HI_FIRST ? 3'b100 : 3'b000;
  localparam logic [2:0] SECOND_OFF = HI_FIRST ? 3'b000 : 3'b100;

  state_t      state_q, state_d;
  logic        insn_pend_q, insn_pend_d;
  logic [28:0] insn_addr_q, insn_addr_d;
  logic [31:0] insn_buf_q, insn_buf_d;
  logic        data_pend_q, data_pend_d;
  logic [29:0] data_addr_q, data_addr_d;
  logic        data_write_q, data_write_d;
  logic [31:0] data_wdata_q, data_wdata_d;
  logic [3:0]  data_be_q, data_be_d;
  logic        insn_ready_q, insn_ready_d;
  logic [63:0] insn_data_q, insn_data_d;
  logic        data_ready_q, data_ready_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic [31:0] avl_address_q, avl_address_d;
  logic        avl_read_q, avl_read_d;
  logic        avl_write_q, avl_write_d;
  logic [31:0] avl_wdata_q, avl_wdata_d;
  logic [3:0]  avl_be_q, avl_be_d;
  logic        grant_data;

  always_comb begin
    state_d       = state_q;
    insn_pend_d   = insn_pend_q;
    insn_addr_d   = insn_addr_q;
    insn_buf_d    = insn_buf_q;
    data_pend_d   = data_pend_q;
    data_addr_d   = data_addr_q;
    data_write_d  = data_write_q;
    data_wdata_d  = data_wdata_q;
    data_be_d     = data_be_q;
    insn_ready_d  = 1'b0;
    insn_data_d   = insn_data_q;
    data_ready_d  = 1'b0;
    data_rdata_d  = data_rdata_q;
    avl_address_d = avl_address_q;
    avl_read_d    = avl_read_q;
    avl_write_d   = avl_write_q;
    avl_wdata_d   = avl_wdata_q;
    avl_be_d      = avl_be_q;
    grant_data    = data_pend_q && (DATA_FIRST || !insn_pend_q);

    // Pending flags clear only on completion, so a start on the ready cycle is accepted
    if (insn_start && !insn_pend_q) begin
      insn_pend_d = 1'b1;
      insn_addr_d = insn_addr;
    end
    if (data_start && !data_pend_q) begin
      data_pend_d  = 1'b1;
      data_addr_d  = data_addr;
      data_write_d = data_write;
      data_wdata_d = data_data_wr;
      data_be_d    = data_data_be;
    end

    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          state_d       = S_DATA;
          avl_address_d = {data_addr_q, 2'b00};
          avl_read_d    = !data_write_q;
          avl_write_d   = data_write_q;
          avl_wdata_d   = data_wdata_q;
          avl_be_d      = data_be_q;
        end else if (insn_pend_q) begin
          state_d       = S_INSN_B0;
          avl_address_d = {insn_addr_q, FIRST_OFF};
          avl_read_d    = 1'b1;
          avl_be_d      = 4'hF;
        end
      end
      S_INSN_B0: begin
        if (!avl_waitrequest) begin
          insn_buf_d    = avl_readdata;
          state_d       = S_INSN_B1;
          avl_address_d = {insn_addr_q, SECOND_OFF};
        end
      end
      S_INSN_B1: begin
        // First word is buffered so insn_data_rd only changes on completion
        if (!avl_waitrequest) begin
          insn_data_d  = HI_FIRST ? {insn_buf_q, avl_readdata} : {avl_readdata, insn_buf_q};
          insn_pend_d  = 1'b0;
          insn_ready_d = 1'b1;
          avl_read_d   = 1'b0;
          state_d      = S_IDLE;
        end
      end
      S_DATA: begin
        if (!avl_waitrequest) begin
          if (!data_write_q) data_rdata_d = avl_readdata;
          data_pend_d  = 1'b0;
          data_ready_d = 1'b1;
          avl_read_d   = 1'b0;
          avl_write_d  = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      insn_pend_q   <= 1'b0;
      insn_addr_q   <= '0;
      insn_buf_q    <= '0;
      data_pend_q   <= 1'b0;
      data_addr_q   <= '0;
      data_write_q  <= 1'b0;
      data_wdata_q  <= '0;
      data_be_q     <= '0;
      insn_ready_q  <= 1'b0;
      insn_data_q   <= '0;
      data_ready_q  <= 1'b0;
      data_rdata_q  <= '0;
      avl_address_q <= '0;
      avl_read_q    <= 1'b0;
      avl_write_q   <= 1'b0;
      avl_wdata_q   <= '0;
      avl_be_q      <= '0;
    end else begin
      state_q       <= state_d;
      insn_pend_q   <= insn_pend_d;
      insn_addr_q   <= insn_addr_d;
      insn_buf_q    <= insn_buf_d;
      data_pend_q   <= data_pend_d;
      data_addr_q   <= data_addr_d;
      data_write_q  <= data_write_d;
      data_wdata_q  <= data_wdata_d;
      data_be_q     <= data_be_d;
      insn_ready_q  <= insn_ready_d;
      insn_data_q   <= insn_data_d;
      data_ready_q  <= data_ready_d;
      data_rdata_q  <= data_rdata_d;
      avl_address_q <= avl_address_d;
      avl_read_q    <= avl_read_d;
      avl_write_q   <= avl_write_d;
      avl_wdata_q   <= avl_wdata_d;
      avl_be_q      <= avl_be_d;
    end
  end

  assign insn_ready     = insn_ready_q;
  assign insn_data_rd   = insn_data_q;
  assign data_ready     = data_ready_q;
  assign data_data_rd   = data_rdata_q;
  assign avl_address    = avl_address_q;
  assign avl_read       = avl_read_q;
  assign avl_write      = avl_write_q;
  assign avl_writedata  = avl_wdata_q;
  assign avl_byteenable = avl_be_q;

endmodule
